// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port GPR array with a per-register pending-write
// counter scoreboard. Decode reads operands and issues instructions; writeback
// retires results. A nonzero counter marks a register whose value is not yet
// final, which stalls dependent issue.
// Optional macro REGFILE_BYPASS_EN: forwards same-cycle writeback data to the
// read ports and clears busy when that writeback retires the last pending write.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 2
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
  input  logic [NUM_RD-1:0]          rd_en_i,
  output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]          rd_busy_o,
  input  logic                       iss_valid_i,
  input  logic                       iss_wr_i,
  input  logic [ADDR_W-1:0]          iss_dst_i,
  output logic                       iss_ready_o,
  input  logic                       wb_valid_i,
  input  logic [ADDR_W-1:0]          wb_addr_i,
  input  logic [DATA_W-1:0]          wb_data_i,
  output logic                       err_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [CNT_W-1:0]  cnt  [DEPTH];
  logic              err_q;

  logic              wb_act;
  logic              err_set;
  logic              iss_fire;
  logic              stall_rd;
  logic              dst_sat;
  logic [DEPTH-1:0]  inc;
  logic [DEPTH-1:0]  dec;

  // Register 0 is hardwired: it never takes writes, counts or errors.
  assign wb_act   = wb_valid_i && (wb_addr_i != '0);
  assign err_set  = wb_act && (cnt[wb_addr_i] == '0);

  // Saturation uses the pre-edge count, so a same-cycle retire does not
  // unblock an issue to a full register (conservative by design).
  assign stall_rd    = |(rd_en_i & rd_busy_o);
  assign dst_sat     = iss_wr_i && (iss_dst_i != '0) && (cnt[iss_dst_i] == CNT_MAX);
  assign iss_ready_o = !stall_rd && !dst_sat;
  assign iss_fire    = iss_valid_i && iss_ready_o;
  assign err_o       = err_q;

  // Combinational read ports with optional writeback forwarding.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign addr = rd_addr_i[k*ADDR_W +: ADDR_W];

    // Per-port data select and busy flag.
    always_comb begin
      data = (addr == '0) ? '0 : regs[addr];
      busy = (addr != '0) && (cnt[addr] != '0);
`ifdef REGFILE_BYPASS_EN
      if (wb_valid_i && (wb_addr_i == addr) && (addr != '0)) begin
        data = wb_data_i;
        if (cnt[addr] == CNT_W'(1)) begin
          busy = 1'b0;
        end
      end
`endif
    end

    assign rd_data_o[k*DATA_W +: DATA_W] = data;
    assign rd_busy_o[k]                  = busy;
  end

  // One-hot increment/decrement requests; a matching pair cancels.
  always_comb begin
    inc = '0;
    dec = '0;
    if (iss_fire && iss_wr_i && (iss_dst_i != '0)) begin
      inc[iss_dst_i] = 1'b1;
    end
    if (wb_act && (cnt[wb_addr_i] != '0)) begin
      dec[wb_addr_i] = 1'b1;
    end
  end

  // Array, counters and sticky error; reset overrides issue and writeback.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      if (wb_act) begin
        regs[wb_addr_i] <= wb_data_i;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (inc[i] && !dec[i]) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else if (dec[i] && !inc[i]) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: expected outputs are queued when the
// stimulus is driven and popped against the DUT when the outputs are sampled.
module tb_regfile_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int CNT_W  = 2;

  logic                     sys_clk = 1'b0;
  logic                     rst_n;
  logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
  logic [NUM_RD-1:0]        rd_en_i;
  logic [NUM_RD*DATA_W-1:0] rd_data_o;
  logic [NUM_RD-1:0]        rd_busy_o;
  logic                     iss_valid_i;
  logic                     iss_wr_i;
  logic [ADDR_W-1:0]        iss_dst_i;
  logic                     iss_ready_o;
  logic                     wb_valid_i;
  logic [ADDR_W-1:0]        wb_addr_i;
  logic [DATA_W-1:0]        wb_data_i;
  logic                     err_o;

  regfile_scoreboard #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .CNT_W(CNT_W)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .rd_addr_i(rd_addr_i), .rd_en_i(rd_en_i),
    .rd_data_o(rd_data_o), .rd_busy_o(rd_busy_o),
    .iss_valid_i(iss_valid_i), .iss_wr_i(iss_wr_i), .iss_dst_i(iss_dst_i),
    .iss_ready_o(iss_ready_o),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .err_o(err_o)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL sb_empty observed=%h required=nothing", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // Queue the expected port values, let inputs settle, then compare.
  task automatic expect_state(input string t, input logic [31:0] d0, d1,
                              input logic [1:0] busy, input logic rdy, err);
    push({t, "_d0"}, d0);
    push({t, "_d1"}, d1);
    push({t, "_busy"}, {30'b0, busy});
    push({t, "_rdy"}, {31'b0, rdy});
    push({t, "_err"}, {31'b0, err});
    #1;
    pop_cmp(rd_data_o[31:0]);
    pop_cmp(rd_data_o[63:32]);
    pop_cmp({30'b0, rd_busy_o});
    pop_cmp({31'b0, iss_ready_o});
    pop_cmp({31'b0, err_o});
  endtask

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    rd_addr_i   = '0;
    rd_en_i     = '0;
    iss_valid_i = 1'b0;
    iss_wr_i    = 1'b0;
    iss_dst_i   = '0;
    wb_valid_i  = 1'b0;
    wb_addr_i   = '0;
    wb_data_i   = '0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state: every index reads zero and nothing is busy.
    for (int i = 0; i < 32; i++) begin
      rd_addr_i = {5'(31 - i), 5'(i)};
      rd_en_i   = 2'b11;
      expect_state("rst_rd", 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
    end
    tick();

    // RAW on r5.
    rd_en_i = 2'b00; rd_addr_i = '0;
    iss_valid_i = 1'b1; iss_wr_i = 1'b1; iss_dst_i = 5'd5;
    expect_state("iss_r5", 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
    tick();
    iss_valid_i = 1'b0; iss_wr_i = 1'b0;
    rd_addr_i = {5'd0, 5'd5}; rd_en_i = 2'b01;
    expect_state("r5_busy", 32'h0, 32'h0, 2'b01, 1'b0, 1'b0);
    wb_valid_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 32'hDEADBEEF;
`ifdef REGFILE_BYPASS_EN
    expect_state("r5_wb", 32'hDEADBEEF, 32'h0, 2'b00, 1'b1, 1'b0);
`else
    expect_state("r5_wb", 32'h0, 32'h0, 2'b01, 1'b0, 1'b0);
`endif
    tick();
    wb_valid_i = 1'b0;
    expect_state("r5_after", 32'hDEADBEEF, 32'h0, 2'b00, 1'b1, 1'b0);

    // WAW on r7 up to the counter limit.
    rd_en_i = 2'b00; rd_addr_i = '0;
    iss_valid_i = 1'b1; iss_wr_i = 1'b1; iss_dst_i = 5'd7;
    for (int j = 0; j < 3; j++) begin
      expect_state("waw_iss", 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
      tick();
    end
    expect_state("waw_full", 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
    iss_valid_i = 1'b0;
    wb_valid_i = 1'b1; wb_addr_i = 5'd7; wb_data_i = 32'h77;
    expect_state("waw_wb", 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
    tick();
    wb_valid_i = 1'b0;
    rd_addr_i = {5'd7, 5'd0};
    expect_state("waw_after", 32'h0, 32'h77, 2'b10, 1'b1, 1'b0);
    iss_wr_i = 1'b0;

    // Same-cycle issue and writeback on r9 with one write outstanding.
    rd_addr_i = '0;
    iss_valid_i = 1'b1; iss_wr_i = 1'b1; iss_dst_i = 5'd9;
    expect_state("r9_iss", 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
    tick();
    wb_valid_i = 1'b1; wb_addr_i = 5'd9; wb_data_i = 32'h1234;
    rd_addr_i = {5'd0, 5'd9};
`ifdef REGFILE_BYPASS_EN
    expect_state("r9_both", 32'h1234, 32'h0, 2'b00, 1'b1, 1'b0);
`else
    expect_state("r9_both", 32'h0, 32'h0, 2'b01, 1'b1, 1'b0);
`endif
    tick();
    iss_valid_i = 1'b0; iss_wr_i = 1'b0; wb_valid_i = 1'b0;
    expect_state("r9_after", 32'h1234, 32'h0, 2'b01, 1'b1, 1'b0);
    wb_valid_i = 1'b1; wb_data_i = 32'h4321;
`ifdef REGFILE_BYPASS_EN
    expect_state("r9_drain", 32'h4321, 32'h0, 2'b00, 1'b1, 1'b0);
`else
    expect_state("r9_drain", 32'h1234, 32'h0, 2'b01, 1'b1, 1'b0);
`endif
    tick();
    wb_valid_i = 1'b0;
    expect_state("r9_clear", 32'h4321, 32'h0, 2'b00, 1'b1, 1'b0);

    // Writeback with nothing pending raises the sticky error.
    rd_addr_i = {5'd0, 5'd3};
    wb_valid_i = 1'b1; wb_addr_i = 5'd3; wb_data_i = 32'h55;
`ifdef REGFILE_BYPASS_EN
    expect_state("r3_wb", 32'h55, 32'h0, 2'b00, 1'b1, 1'b0);
`else
    expect_state("r3_wb", 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
`endif
    tick();
    wb_valid_i = 1'b0;
    expect_state("r3_err", 32'h55, 32'h0, 2'b00, 1'b1, 1'b1);
    tick();
    expect_state("r3_sticky", 32'h55, 32'h0, 2'b00, 1'b1, 1'b1);

    // Mid-operation reset clears data, the pending r7 writes and the error.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rd_addr_i = {5'd7, 5'd3};
    expect_state("post_rst", 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
    rd_addr_i = {5'd9, 5'd5};
    expect_state("post_rst2", 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
    rd_addr_i = {5'd7, 5'd3}; rd_en_i = 2'b11;
    expect_state("post_rst_rdy", 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);

    // Register 0 ignores issue and writeback.
    rd_addr_i = '0; rd_en_i = 2'b11;
    iss_valid_i = 1'b1; iss_wr_i = 1'b1; iss_dst_i = 5'd0;
    wb_valid_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'hFFFFFFFF;
    expect_state("r0_wb", 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
    for (int j = 0; j < 4; j++) begin
      tick();
      expect_state("r0_hold", 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
    end
    iss_valid_i = 1'b0; iss_wr_i = 1'b0; wb_valid_i = 1'b0;
    tick();
    expect_state("r0_final", 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
